// File: rtl/sub_bytes_sequencer_if.sv
// Handshake and data bundle for the SubBytes sequencer.
// master: round controller side (drives start/inv/state_in).
// slave:  sequencer side (drives ready/done/state_out).
interface sub_bytes_sequencer_if;
  logic         start;
  logic         inv;
  logic [127:0] state_in;
  logic         ready;
  logic         done;
  logic [127:0] state_out;

  modport master (output start, inv, state_in, input ready, done, state_out);
  modport slave  (input start, inv, state_in, output ready, done, state_out);
endinterface

// File: rtl/sub_bytes_sequencer.sv
// Multi-cycle AES SubBytes: streams the 16-byte state through LANES
// registered S-box lanes and reassembles it, pulsing done with the result.
// Optional feature macro INV_SUBBYTES_EN: adds an inverse S-box per lane,
// selected by the inv flag captured at start. Without it, inv is ignored.
//
// state | meaning
// IDLE  | ready=1, waiting for start; state_out holds last result
// ISSUE | one beat of LANES bytes sent to the S-boxes per cycle
// DRAIN | last beat leaves the S-box registers; state_out loaded, done=1
module sub_bytes_sequencer #(
  parameter int LANES = 4
) (
  input logic                  clk,
  input logic                  reset_n,
  sub_bytes_sequencer_if.slave bus
);
  localparam int N  = 16 / LANES;
  localparam int LW = 8 * LANES;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [127:0]   data_q, data_d;
  logic [127:0]   shadow_q, shadow_d;
  logic [127:0]   out_q, out_d;
  logic [LW-1:0]  sbox_q, sbox_d;
  logic [LW-1:0]  lut_out;
  logic           done_q, done_d;
  logic           inv_q, inv_d;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse in GF(2^8); maps 0 to 0 as AES needs
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] r;
    sq = a;
    r  = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int k);
    return 8'((v << k) | (v >> (8 - k)));
  endfunction

  function automatic logic [7:0] fwd_sbox(input logic [7:0] a);
    logic [7:0] s;
    s = gf_inv(a);
    return s ^ rotl(s, 1) ^ rotl(s, 2) ^ rotl(s, 3) ^ rotl(s, 4) ^ 8'h63;
  endfunction

`ifdef INV_SUBBYTES_EN
  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return gf_inv(rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05);
  endfunction
`else
  logic unused_inv;
  assign unused_inv = bus.inv;
`endif

  // per-lane S-box lookup on the top LANES bytes of the shifting data register
  always_comb begin
    lut_out = '0;
    for (int l = 0; l < LANES; l++) begin
`ifdef INV_SUBBYTES_EN
      lut_out[LW-1-8*l -: 8] = inv_q ? inv_sbox(data_q[127-8*l -: 8])
                                     : fwd_sbox(data_q[127-8*l -: 8]);
`else
      lut_out[LW-1-8*l -: 8] = fwd_sbox(data_q[127-8*l -: 8]);
`endif
    end
  end

  // next-state, beat counter and datapath updates
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    shadow_d = shadow_q;
    out_d    = out_q;
    sbox_d   = sbox_q;
    inv_d    = inv_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          data_d   = bus.state_in;
          inv_d    = bus.inv;
          cnt_d    = '0;
          shadow_d = '0;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        sbox_d = lut_out;
        data_d = data_q << LW;
        // from the second beat on, the S-box register holds the previous beat
        if (cnt_q != '0) shadow_d = (shadow_q << LW) | 128'(sbox_q);
        if (cnt_q == LAST_BEAT) begin
          cnt_d   = '0;
          state_d = DRAIN;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DRAIN: begin
        out_d   = (shadow_q << LW) | 128'(sbox_q);
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      data_q   <= '0;
      shadow_q <= '0;
      out_q    <= '0;
      sbox_q   <= '0;
      inv_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      shadow_q <= shadow_d;
      out_q    <= out_d;
      sbox_q   <= sbox_d;
      inv_q    <= inv_d;
      done_q   <= done_d;
    end
  end

  assign bus.ready     = (state_q == IDLE);
  assign bus.done      = done_q;
  assign bus.state_out = out_q;
endmodule

// File: tb/tb_sub_bytes_sequencer.sv
// Directed bench for sub_bytes_sequencer: LANES=4 vector table run
// back-to-back, corner-case sequences, and a LANES=1/2/8/16 sweep
// against a table-based S-box model.
module tb_sub_bytes_sequencer;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

`ifdef INV_SUBBYTES_EN
  localparam bit HAS_INV = 1'b1;
`else
  localparam bit HAS_INV = 1'b0;
`endif

  localparam logic [2047:0] SBOX_P = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  logic [2047:0] sbox_bits;
  logic [7:0]    sbox_m [256];
  logic [7:0]    inv_m  [256];

  function automatic logic [127:0] model(input logic [127:0] s, input logic inv);
    logic [127:0] r;
    logic [7:0]   b;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      b = s[127-8*i -: 8];
      r[127-8*i -: 8] = (inv && HAS_INV) ? inv_m[b] : sbox_m[b];
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // main LANES=4 instance
  sub_bytes_sequencer_if bus();
  sub_bytes_sequencer #(.LANES(4)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  // sweep instances LANES = 1, 2, 8, 16 sharing one stimulus
  logic         sw_start = 1'b0;
  logic         sw_inv = 1'b0;
  logic [127:0] sw_state = '0;
  wire          sw_done [4];
  wire [127:0]  sw_out  [4];

  for (genvar g = 0; g < 4; g++) begin : g_sw
    sub_bytes_sequencer_if sbus();
    assign sbus.start    = sw_start;
    assign sbus.inv      = sw_inv;
    assign sbus.state_in = sw_state;
    assign sw_done[g]    = sbus.done;
    assign sw_out[g]     = sbus.state_out;
    sub_bytes_sequencer #(.LANES((g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 8 : 16)) u_dut (
      .clk(clk), .reset_n(reset_n), .bus(sbus));
  end

  typedef struct {
    logic [127:0] state;
    logic         inv;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs [7];

  // starts at a negedge; returns at the negedge where done is seen (or bound hit)
  task automatic run_op(input logic [127:0] s, input logic inv, output int lat);
    bus.start    = 1'b1;
    bus.state_in = s;
    bus.inv      = inv;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.state_in = ~s;
    bus.inv      = ~inv;
    lat = 0;
    while (!bus.done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat;
    int ndone;
    int first_lat;
    logic [127:0] first_out;
    int sw_lat [4];
    logic [127:0] sw_res [4];
    int sw_exp_lat [4];

    sw_exp_lat = '{17, 9, 3, 2};
    bus.start = 1'b0;
    bus.inv = 1'b0;
    bus.state_in = '0;

    sbox_bits = SBOX_P;
    for (int i = 0; i < 256; i++) begin
      sbox_m[i] = sbox_bits[2047-8*i -: 8];
      inv_m[sbox_bits[2047-8*i -: 8]] = 8'(i);
    end

    vecs[0] = '{128'h00112233445566778899aabbccddeeff, 1'b0, 128'h638293c31bfc33f5c4eeacea4bc12816};
    vecs[1] = '{128'h638293c31bfc33f5c4eeacea4bc12816, 1'b1,
                HAS_INV ? 128'h00112233445566778899aabbccddeeff
                        : model(128'h638293c31bfc33f5c4eeacea4bc12816, 1'b0)};
    vecs[2] = '{128'h0, 1'b0, {16{8'h63}}};
    vecs[3] = '{128'h0, 1'b1, HAS_INV ? {16{8'h52}} : {16{8'h63}}};
    vecs[4] = '{{16{8'hff}}, 1'b0, {16{8'h16}}};
    vecs[5] = '{128'h000102030405060708090a0b0c0d0e0f, 1'b0, 128'h637c777bf26b6fc53001672bfed7ab76};
    vecs[6] = '{128'h637c777bf26b6fc53001672bfed7ab76, 1'b1,
                HAS_INV ? 128'h000102030405060708090a0b0c0d0e0f
                        : model(128'h637c777bf26b6fc53001672bfed7ab76, 1'b0)};

    // reset values
    #1;
    check("rst_ready", 128'(bus.ready), 128'd1);
    check("rst_done", 128'(bus.done), 128'd0);
    check("rst_out", bus.state_out, 128'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // table: each vector starts in the done cycle of the previous one
    for (int v = 0; v < 7; v++) begin
      bus.start    = 1'b1;
      bus.state_in = vecs[v].state;
      bus.inv      = vecs[v].inv;
      @(negedge clk);
      check($sformatf("v%0d_busy", v), 128'(bus.ready), 128'd0);
      bus.start    = 1'b0;
      bus.state_in = ~vecs[v].state;
      bus.inv      = ~vecs[v].inv;
      lat = 0;
      while (!bus.done && lat < 40) begin
        @(negedge clk);
        lat++;
      end
      check($sformatf("v%0d_lat", v), 128'(lat), 128'd5);
      check($sformatf("v%0d_out", v), bus.state_out, vecs[v].exp);
      check($sformatf("v%0d_ready_done", v), 128'(bus.ready), 128'd1);
    end

    // result holds while idle, no spurious done
    ndone = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    check("idle_done_cnt", 128'(ndone), 128'd0);
    check("idle_hold", bus.state_out, vecs[6].exp);

    // start pulsed mid-operation is ignored
    bus.start    = 1'b1;
    bus.state_in = 128'h00112233445566778899aabbccddeeff;
    bus.inv      = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    ndone = 0;
    first_lat = -1;
    first_out = '0;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (k == 2) begin
        check("mid_ready", 128'(bus.ready), 128'd0);
        bus.start    = 1'b1;
        bus.state_in = '0;
      end
      if (k == 3) bus.start = 1'b0;
      if (bus.done) begin
        ndone++;
        if (first_lat < 0) begin
          first_lat = k;
          first_out = bus.state_out;
        end
      end
    end
    check("mid_done_cnt", 128'(ndone), 128'd1);
    check("mid_lat", 128'(first_lat), 128'd5);
    check("mid_out", first_out, 128'h638293c31bfc33f5c4eeacea4bc12816);

    // asynchronous reset in cycle 3 of an operation
    bus.start    = 1'b1;
    bus.state_in = {16{8'h5a}};
    bus.inv      = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("arst_ready", 128'(bus.ready), 128'd1);
    check("arst_done", 128'(bus.done), 128'd0);
    check("arst_out", bus.state_out, 128'd0);
    ndone = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    reset_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    check("arst_no_done", 128'(ndone), 128'd0);
    check("arst_out_held", bus.state_out, 128'd0);
    run_op({16{8'hff}}, 1'b0, lat);
    check("post_rst_lat", 128'(lat), 128'd5);
    check("post_rst_out", bus.state_out, {16{8'h16}});
    @(negedge clk);

    // LANES sweep with random states
    for (int r = 0; r < 4; r++) begin
      sw_state = {$urandom, $urandom, $urandom, $urandom};
      sw_inv   = r[0];
      sw_start = 1'b1;
      for (int i = 0; i < 4; i++) begin
        sw_lat[i] = -1;
        sw_res[i] = '0;
      end
      @(negedge clk);
      sw_start = 1'b0;
      for (int k = 1; k <= 25; k++) begin
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
          if (sw_done[i] && sw_lat[i] < 0) begin
            sw_lat[i] = k;
            sw_res[i] = sw_out[i];
          end
        end
      end
      for (int i = 0; i < 4; i++) begin
        check($sformatf("sw%0d_i%0d_lat", r, i), 128'(sw_lat[i]), 128'(sw_exp_lat[i]));
        check($sformatf("sw%0d_i%0d_out", r, i), sw_res[i], model(sw_state, sw_inv));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
